// File: rtl/alu_issue_stage.sv
// RV32I ID->EX issue register: decodes the instruction and operands into ALU opcode and operands.
// Optional macro ILLEGAL_INSN_EN adds the registered o_illegal flag.
module alu_issue_stage #(
    parameter int d_width = 32,
    parameter int op      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instr,
    input  logic [d_width-1:0] i_pc,
    input  logic [d_width-1:0] i_rs1_data,
    input  logic [d_width-1:0] i_rs2_data,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [op-1:0]      o_alu_opcode,
    output logic [d_width-1:0] o_alu_data1,
    output logic [d_width-1:0] o_alu_data2,
    output logic [4:0]         o_rd,
    output logic               o_rd_we,
    output logic [2:0]         o_funct3
`ifdef ILLEGAL_INSN_EN
    ,
    output logic               o_illegal
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [op-1:0] ALU_ADD  = op'(0);
    localparam logic [op-1:0] ALU_SUB  = op'(1);
    localparam logic [op-1:0] ALU_SLL  = op'(2);
    localparam logic [op-1:0] ALU_SLT  = op'(3);
    localparam logic [op-1:0] ALU_SLTU = op'(4);
    localparam logic [op-1:0] ALU_XOR  = op'(5);
    localparam logic [op-1:0] ALU_SRL  = op'(6);
    localparam logic [op-1:0] ALU_SRA  = op'(7);
    localparam logic [op-1:0] ALU_OR   = op'(8);
    localparam logic [op-1:0] ALU_AND  = op'(9);

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [4:0]         rd;
    logic               is_shift;
    logic [d_width-1:0] imm_i, imm_s, imm_u, shamt_i, shamt_r;

    assign opc      = i_instr[6:0];
    assign f3       = i_instr[14:12];
    assign rd       = i_instr[11:7];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign imm_i    = {{(d_width-12){i_instr[31]}}, i_instr[31:20]};
    assign imm_s    = {{(d_width-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_u    = d_width'({i_instr[31:12], 12'b0});
    assign shamt_i  = d_width'(i_instr[24:20]);
    assign shamt_r  = d_width'(i_rs2_data[4:0]);

    // alt selects sub on f3=000 and sra on f3=101; ignored elsewhere
    function automatic logic [op-1:0] alu_for_f3(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  alu_for_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_for_f3 = ALU_SLL;
            3'b010:  alu_for_f3 = ALU_SLT;
            3'b011:  alu_for_f3 = ALU_SLTU;
            3'b100:  alu_for_f3 = ALU_XOR;
            3'b101:  alu_for_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_for_f3 = ALU_OR;
            default: alu_for_f3 = ALU_AND;
        endcase
    endfunction

    logic [op-1:0]      nxt_opcode;
    logic [d_width-1:0] nxt_data1, nxt_data2;
    logic               nxt_writes, nxt_rd_we;

    always_comb begin
        nxt_opcode = ALU_ADD;
        nxt_data1  = '0;
        nxt_data2  = '0;
        nxt_writes = 1'b0;
        case (opc)
            OPC_OP: begin
                nxt_opcode = alu_for_f3(f3, i_instr[30]);
                nxt_data1  = i_rs1_data;
                nxt_data2  = is_shift ? shamt_r : i_rs2_data;
                nxt_writes = 1'b1;
            end
            OPC_OPIMM: begin
                nxt_opcode = alu_for_f3(f3, (f3 == 3'b101) && i_instr[30]);
                nxt_data1  = i_rs1_data;
                nxt_data2  = is_shift ? shamt_i : imm_i;
                nxt_writes = 1'b1;
            end
            OPC_LUI: begin
                nxt_data2  = imm_u;
                nxt_writes = 1'b1;
            end
            OPC_AUIPC: begin
                nxt_data1  = i_pc;
                nxt_data2  = imm_u;
                nxt_writes = 1'b1;
            end
            OPC_LOAD: begin
                nxt_data1  = i_rs1_data;
                nxt_data2  = imm_i;
                nxt_writes = 1'b1;
            end
            OPC_STORE: begin
                nxt_data1 = i_rs1_data;
                nxt_data2 = imm_s;
            end
            OPC_BRANCH: begin
                nxt_opcode = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                nxt_data1  = i_rs1_data;
                nxt_data2  = i_rs2_data;
            end
            OPC_JAL, OPC_JALR: begin
                nxt_data1  = i_pc;
                nxt_data2  = d_width'(4);
                nxt_writes = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_INSN_EN
    logic [6:0] f7;
    logic       nxt_illegal;

    assign f7 = i_instr[31:25];

    always_comb begin
        nxt_illegal = 1'b0;
        case (opc)
            OPC_OP:
                nxt_illegal = !((f7 == 7'h00) ||
                                ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            OPC_OPIMM:
                nxt_illegal = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                              ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
            OPC_BRANCH:
                nxt_illegal = (f3[2:1] == 2'b01);
            OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR:
                nxt_illegal = 1'b0;
            default:
                nxt_illegal = 1'b1;
        endcase
    end

    assign nxt_rd_we = nxt_writes && (rd != 5'd0) && !nxt_illegal;
`else
    assign nxt_rd_we = nxt_writes && (rd != 5'd0);
`endif

    logic load;

    assign o_ready = !o_valid || i_ready;
    assign load    = i_valid && o_ready && !i_flush;

    // flush clears only the valid bit; payload registers keep their last contents
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_alu_opcode <= '0;
            o_alu_data1  <= '0;
            o_alu_data2  <= '0;
            o_rd         <= '0;
            o_rd_we      <= 1'b0;
            o_funct3     <= '0;
        end else begin
            if (i_flush)
                o_valid <= 1'b0;
            else if (load)
                o_valid <= 1'b1;
            else if (i_ready)
                o_valid <= 1'b0;
            if (load) begin
                o_alu_opcode <= nxt_opcode;
                o_alu_data1  <= nxt_data1;
                o_alu_data2  <= nxt_data2;
                o_rd         <= rd;
                o_rd_we      <= nxt_rd_we;
                o_funct3     <= f3;
            end
        end
    end

`ifdef ILLEGAL_INSN_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_illegal <= 1'b0;
        else if (load)
            o_illegal <= nxt_illegal;
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus random traffic against a decode model.
module tb_alu_issue_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_alu_opcode;
    logic [31:0] o_alu_data1;
    logic [31:0] o_alu_data2;
    logic [4:0]  o_rd;
    logic        o_rd_we;
    logic [2:0]  o_funct3;
`ifdef ILLEGAL_INSN_EN
    logic        o_illegal;
`endif

    alu_issue_stage #(.d_width(32), .op(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_instr      (i_instr),
        .i_pc         (i_pc),
        .i_rs1_data   (i_rs1_data),
        .i_rs2_data   (i_rs2_data),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_alu_opcode (o_alu_opcode),
        .o_alu_data1  (o_alu_data1),
        .o_alu_data2  (o_alu_data2),
        .o_rd         (o_rd),
        .o_rd_we      (o_rd_we),
        .o_funct3     (o_funct3)
`ifdef ILLEGAL_INSN_EN
        ,
        .o_illegal    (o_illegal)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t m;
    logic m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        int   plain_op [8];
        int   fn, f7, s;
        bit   writes;
        plain_op = '{0, 2, 3, 4, 5, 6, 8, 9};
        fn = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        writes = 1'b0;
        e = '0;
        e.rd = ins[11:7];
        e.f3 = ins[14:12];
        case (ins[6:0])
            7'h33: begin
                e.op = 4'(plain_op[fn]);
                if (ins[30] && fn == 0) e.op = 4'd1;
                if (ins[30] && fn == 5) e.op = 4'd7;
                e.d1 = rs1;
                e.d2 = (fn == 1 || fn == 5) ? rs2 % 32 : rs2;
                e.ill = !(f7 == 0 || (f7 == 32 && (fn == 0 || fn == 5)));
                writes = 1'b1;
            end
            7'h13: begin
                e.op = 4'(plain_op[fn]);
                if (ins[30] && fn == 5) e.op = 4'd7;
                e.d1 = rs1;
                e.d2 = (fn == 1 || fn == 5) ? 32'(ins[24:20]) : 32'($signed(ins) >>> 20);
                e.ill = (fn == 1 && f7 != 0) || (fn == 5 && f7 != 0 && f7 != 32);
                writes = 1'b1;
            end
            7'h37: begin e.d2 = ins & 32'hFFFF_F000; writes = 1'b1; end
            7'h17: begin e.d1 = pc; e.d2 = ins & 32'hFFFF_F000; writes = 1'b1; end
            7'h03: begin e.d1 = rs1; e.d2 = 32'($signed(ins) >>> 20); writes = 1'b1; end
            7'h23: begin
                s = int'({ins[31:25], ins[11:7]});
                if (s >= 2048) s -= 4096;
                e.d1 = rs1;
                e.d2 = 32'(s);
            end
            7'h63: begin
                e.op = (fn >= 6) ? 4'd4 : (fn >= 4) ? 4'd3 : 4'd1;
                e.d1 = rs1;
                e.d2 = rs2;
                e.ill = (fn == 2 || fn == 3);
            end
            7'h6F, 7'h67: begin e.d1 = pc; e.d2 = 32'd4; writes = 1'b1; end
            default: e.ill = 1'b1;
        endcase
`ifdef ILLEGAL_INSN_EN
        e.we = writes && (e.rd != 0) && !e.ill;
`else
        e.we = writes && (e.rd != 0);
        e.ill = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        logic [6:0]  opcs [12];
        int          k;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h0F, 7'h73};
        ins = $urandom;
        k = $urandom_range(0, 11);
        ins[6:0] = opcs[k];
        if (opcs[k] == 7'h33 && $urandom_range(0, 3) != 0) begin
            if (ins[14:12] == 3'b000 || ins[14:12] == 3'b101) ins[31:25] = {1'b0, ins[30], 5'b0};
            else ins[31:25] = 7'h00;
        end
        if (opcs[k] == 7'h13 && $urandom_range(0, 3) != 0) begin
            if (ins[14:12] == 3'b001) ins[31:25] = 7'h00;
            if (ins[14:12] == 3'b101) ins[31:25] = {1'b0, ins[30], 5'b0};
        end
        if (opcs[k] == 7'h63 && ins[14:13] == 2'b01) ins[14] = 1'b1;
        return ins;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic v, input logic r, input logic f);
        i_instr = ins; i_pc = pc; i_rs1_data = rs1; i_rs2_data = rs2;
        i_valid = v; i_ready = r; i_flush = f;
    endtask

    // Advance one clock while tracking the expected register contents
    task automatic tick();
        logic rdy;
        rdy = !m_valid || i_ready;
        @(posedge i_clk);
        if (i_flush)
            m_valid = 1'b0;
        else if (i_valid && rdy) begin
            m = ref_decode(i_instr, i_pc, i_rs1_data, i_rs2_data);
            m_valid = 1'b1;
        end else if (i_ready)
            m_valid = 1'b0;
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'(m_valid));
        check({tag, "_ready"}, 32'(o_ready), 32'(!m_valid || i_ready));
        check({tag, "_opcode"}, 32'(o_alu_opcode), 32'(m.op));
        check({tag, "_data1"}, o_alu_data1, m.d1);
        check({tag, "_data2"}, o_alu_data2, m.d2);
        check({tag, "_rd"}, 32'(o_rd), 32'(m.rd));
        check({tag, "_rd_we"}, 32'(o_rd_we), 32'(m.we));
        check({tag, "_funct3"}, 32'(o_funct3), 32'(m.f3));
`ifdef ILLEGAL_INSN_EN
        check({tag, "_illegal"}, 32'(o_illegal), 32'(m.ill));
`endif
    endtask

    initial begin
        i_rst_n = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        m = '0;
        m_valid = 1'b0;
        #12;
        check_all("reset");
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        drive(32'h402081B3, 32'h0, 32'd10, 32'd3, 1'b1, 1'b1, 1'b0);
        tick(); check_all("sub");
        check("sub_opcode_k", 32'(o_alu_opcode), 32'h1);
        check("sub_data1_k", o_alu_data1, 32'd10);
        check("sub_data2_k", o_alu_data2, 32'd3);
        check("sub_rd_k", 32'(o_rd), 32'd3);
        check("sub_we_k", 32'(o_rd_we), 32'd1);

        drive(32'h40435293, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0);
        tick(); check_all("srai");
        check("srai_opcode_k", 32'(o_alu_opcode), 32'h7);
        check("srai_data2_k", o_alu_data2, 32'd4);

        drive(32'h003110B3, 32'h0, 32'h1234, 32'h25, 1'b1, 1'b1, 1'b0);
        tick(); check_all("sll");
        check("sll_opcode_k", 32'(o_alu_opcode), 32'h2);
        check("sll_data2_k", o_alu_data2, 32'd5);

        drive(32'h0020E063, 32'h40, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
        tick(); check_all("bltu");
        check("bltu_opcode_k", 32'(o_alu_opcode), 32'h4);
        check("bltu_we_k", 32'(o_rd_we), 32'd0);

        drive(32'h00001097, 32'h100, 32'h55, 32'h66, 1'b1, 1'b1, 1'b0);
        tick(); check_all("auipc");
        check("auipc_data1_k", o_alu_data1, 32'h100);
        check("auipc_data2_k", o_alu_data2, 32'h1000);

        for (int i = 0; i < 3; i++) begin
            drive(32'h003100B3 + 32'(i << 7), 32'h200, 32'(i + 7), 32'h9, 1'b1, 1'b0, 1'b0);
            tick(); check_all("hold");
            check("hold_ready_k", 32'(o_ready), 32'd0);
            check("hold_valid_k", 32'(o_valid), 32'd1);
            check("hold_data2_k", o_alu_data2, 32'h1000);
        end
        i_flush = 1'b1;
        tick(); check_all("flush");
        check("flush_valid_k", 32'(o_valid), 32'd0);
        check("flush_data1_k", o_alu_data1, 32'h100);

        drive(32'h0000057F, 32'h300, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0);
        tick(); check_all("bad_opc");
        check("bad_opc_opcode_k", 32'(o_alu_opcode), 32'h0);
        check("bad_opc_data1_k", o_alu_data1, 32'h0);
        check("bad_opc_data2_k", o_alu_data2, 32'h0);
        check("bad_opc_we_k", 32'(o_rd_we), 32'd0);
`ifdef ILLEGAL_INSN_EN
        check("bad_opc_illegal_k", 32'(o_illegal), 32'd1);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(gen_instr(), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
            tick(); check_all("rand");
        end

        drive(32'h402081B3, 32'h0, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h402081B3, 32'h0, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0);
        tick(); check_all("pre_rst");
        check("pre_rst_valid_k", 32'(o_valid), 32'd1);
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        m = '0;
        m_valid = 1'b0;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_opcode", 32'(o_alu_opcode), 32'd0);
        check_all("async_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick(); check_all("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
